// File: rtl/result_retire_pipe_pkg.sv
// Shared constants and helpers for the MEM/WB retire pipeline.
// Width defaults track the register bus and register address bus widths.
package result_retire_pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 32;

  // Bit positions inside stall_i
  localparam int STALL_MEM = 0;
  localparam int STALL_WB  = 1;

  // A held WB stage with a running MEM stage cannot be honoured without losing
  // an entry, so that combination is promoted to a full hold.
  function automatic logic [1:0] legal_stall(input logic [1:0] stall);
    legal_stall = stall[STALL_WB] ? 2'b11 : stall;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register carrying a wd/wreg/wdata triple.
// Priority: rst/clear > hold > bubble > load.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              hold,
  input  logic              bubble,
  input  logic [ADDR_W-1:0] wd_d,
  input  logic              wreg_d,
  input  logic [DATA_W-1:0] wdata_d,
  output logic [ADDR_W-1:0] wd_q,
  output logic              wreg_q,
  output logic [DATA_W-1:0] wdata_q
);

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of its upstream neighbour.
  always_ff @(posedge clk) begin
    if (rst || clear || (bubble && !hold)) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
    end else if (!hold) begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: rtl/result_retire_pipe.sv
// MEM and WB stages behind the execute result interface: regfile write port,
// operand forwarding back to decode, and a count of retired register writes.
module result_retire_pipe
  import result_retire_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic [1:0]        stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] id_raddr1_i,
  input  logic [ADDR_W-1:0] id_raddr2_i,
  output logic              fwd1_hit_o,
  output logic [DATA_W-1:0] fwd1_data_o,
  output logic              fwd2_hit_o,
  output logic [DATA_W-1:0] fwd2_data_o,
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  logic [1:0]        stall;
  logic [ADDR_W-1:0] mem_wd;
  logic              mem_wreg;
  logic [DATA_W-1:0] mem_wdata;
  logic              retire;

  assign stall = legal_stall(stall_i);

  pipe_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush_i),
    .hold    (stall[STALL_MEM]),
    .bubble  (1'b0),
    .wd_d    (ex_wd_i),
    .wreg_d  (ex_wreg_i),
    .wdata_d (ex_wdata_i),
    .wd_q    (mem_wd),
    .wreg_q  (mem_wreg),
    .wdata_q (mem_wdata)
  );

  // While MEM holds and WB runs, WB takes a bubble so the held entry retires once.
  pipe_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wb (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush_i),
    .hold    (stall[STALL_WB]),
    .bubble  (stall[STALL_MEM]),
    .wd_d    (mem_wd),
    .wreg_d  (mem_wreg),
    .wdata_d (mem_wdata),
    .wd_q    (wb_wd_o),
    .wreg_q  (wb_wreg_o),
    .wdata_q (wb_wdata_o)
  );

  // Youngest matching producer wins; register 0 is never forwarded.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] raddr);
    fwd_lookup = '0;
    if (raddr != '0) begin
      if (ex_wreg_i && ex_wd_i == raddr)
        fwd_lookup = {1'b1, ex_wdata_i};
      else if (mem_wreg && mem_wd == raddr)
        fwd_lookup = {1'b1, mem_wdata};
      else if (wb_wreg_o && wb_wd_o == raddr)
        fwd_lookup = {1'b1, wb_wdata_o};
    end
  endfunction

  always_comb begin
    {fwd1_hit_o, fwd1_data_o} = fwd_lookup(id_raddr1_i);
    {fwd2_hit_o, fwd2_data_o} = fwd_lookup(id_raddr2_i);
  end

  // A flush still lets the current WB entry commit before the stage is cleared.
  assign retire = wb_wreg_o && (wb_wd_o != '0) && (!stall[STALL_WB] || flush_i);

  always_ff @(posedge clk) begin
    if (rst)
      retire_cnt_o <= '0;
    else if (retire)
      retire_cnt_o <= retire_cnt_o + 1'b1;
  end

endmodule

// File: tb/tb_result_retire_pipe.sv
// Randomized scoreboard bench for result_retire_pipe against a rule-level model.
module tb_result_retire_pipe;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 8;  // narrow counter so the wrap is reachable

  typedef struct {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
  } ent_t;

  typedef struct {
    logic              f1_hit;
    logic [DATA_W-1:0] f1_data;
    logic              f2_hit;
    logic [DATA_W-1:0] f2_data;
    ent_t              wb;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] ex_wd_i;
  logic              ex_wreg_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic [1:0]        stall_i;
  logic              flush_i;
  logic [ADDR_W-1:0] id_raddr1_i;
  logic [ADDR_W-1:0] id_raddr2_i;
  logic              fwd1_hit_o;
  logic [DATA_W-1:0] fwd1_data_o;
  logic              fwd2_hit_o;
  logic [DATA_W-1:0] fwd2_data_o;
  logic [ADDR_W-1:0] wb_wd_o;
  logic              wb_wreg_o;
  logic [DATA_W-1:0] wb_wdata_o;
  logic [CNT_W-1:0]  retire_cnt_o;

  result_retire_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_wd_i      (ex_wd_i),
    .ex_wreg_i    (ex_wreg_i),
    .ex_wdata_i   (ex_wdata_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .id_raddr1_i  (id_raddr1_i),
    .id_raddr2_i  (id_raddr2_i),
    .fwd1_hit_o   (fwd1_hit_o),
    .fwd1_data_o  (fwd1_data_o),
    .fwd2_hit_o   (fwd2_hit_o),
    .fwd2_data_o  (fwd2_data_o),
    .wb_wd_o      (wb_wd_o),
    .wb_wreg_o    (wb_wreg_o),
    .wb_wdata_o   (wb_wdata_o),
    .retire_cnt_o (retire_cnt_o)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   illegal_stalls = 0;
  exp_t exp_q[$];

  // Reference model state: pipe[0] is MEM, pipe[1] is WB.
  ent_t pipe[2];
  int   m_cnt;
  bit   m_known = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cycle, act, req);
    end
  endtask

  function automatic void model_fwd(input logic [ADDR_W-1:0] raddr, input ent_t ex,
                                    output logic hit, output logic [DATA_W-1:0] data);
    ent_t cand[3];
    cand[0] = ex; cand[1] = pipe[0]; cand[2] = pipe[1];
    hit = 1'b0; data = '0;
    if (raddr == 0) return;
    for (int i = 0; i < 3; i++)
      if (cand[i].wreg && cand[i].wd == raddr) begin
        hit = 1'b1; data = cand[i].wdata; return;
      end
  endfunction

  function automatic void model_edge(input logic r, input logic f, input logic [1:0] st, input ent_t ex);
    ent_t zero;
    zero = '{wd: '0, wreg: 1'b0, wdata: '0};
    if (r) begin
      pipe[0] = zero; pipe[1] = zero; m_cnt = 0; m_known = 1;
      return;
    end
    if (pipe[1].wreg && pipe[1].wd != 0 && (!st[1] || f))
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (f) begin
      pipe[0] = zero; pipe[1] = zero;
    end else if (st == 2'b00) begin
      pipe[1] = pipe[0]; pipe[0] = ex;
    end else if (st == 2'b01) begin
      pipe[1] = zero;
    end
    // 11 and 10: both stages keep their contents
  endfunction

  task automatic step(input logic r, input logic f, input logic [1:0] st,
                      input logic [ADDR_W-1:0] wd, input logic wr, input logic [DATA_W-1:0] wdat,
                      input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    ent_t ex;
    exp_t e;
    rst = r; flush_i = f; stall_i = st;
    ex_wd_i = wd; ex_wreg_i = wr; ex_wdata_i = wdat;
    id_raddr1_i = a1; id_raddr2_i = a2;
    ex = '{wd: wd, wreg: wr, wdata: wdat};
    if (st == 2'b10 && !r && !f) begin
      illegal_stalls++;
      $display("note: illegal stall_i=10 driven at cycle %0d", cycle);
    end
    if (m_known) begin
      model_fwd(a1, ex, e.f1_hit, e.f1_data);
      model_fwd(a2, ex, e.f2_hit, e.f2_data);
      e.wb  = pipe[1];
      e.cnt = m_cnt[CNT_W-1:0];
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_edge(r, f, st, ex);
    cycle++;
    #1;
  endtask

  task automatic idle(input int n, input logic [ADDR_W-1:0] a1);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, '0, 1'b0, '0, a1, '0);
  endtask

  // Monitor: compare every expected observation in the quiet half of the cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fwd1_hit",  {31'b0, fwd1_hit_o}, {31'b0, e.f1_hit});
        check("fwd1_data", fwd1_data_o, e.f1_data);
        check("fwd2_hit",  {31'b0, fwd2_hit_o}, {31'b0, e.f2_hit});
        check("fwd2_data", fwd2_data_o, e.f2_data);
        check("wb_wd",     {{(DATA_W-ADDR_W){1'b0}}, wb_wd_o}, {{(DATA_W-ADDR_W){1'b0}}, e.wb.wd});
        check("wb_wreg",   {31'b0, wb_wreg_o}, {31'b0, e.wb.wreg});
        check("wb_wdata",  wb_wdata_o, e.wb.wdata);
        check("retire_cnt", {{(DATA_W-CNT_W){1'b0}}, retire_cnt_o}, {{(DATA_W-CNT_W){1'b0}}, e.cnt});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst = 1'b1; flush_i = 1'b0; stall_i = 2'b00;
    ex_wd_i = '0; ex_wreg_i = 1'b0; ex_wdata_i = '0;
    id_raddr1_i = '0; id_raddr2_i = '0;
    @(posedge clk); #1;

    // Reset, then a single write to r5 reaching WB two cycles later
    step(1, 0, 2'b00, '0, 0, '0, '0, '0);
    step(1, 0, 2'b00, '0, 0, '0, '0, '0);
    step(0, 0, 2'b00, 5'd5, 1, 32'h1234, 5'd5, 5'd0);
    idle(3, 5'd5);

    // Back-to-back writes to r7: forward always returns the EX value
    step(0, 0, 2'b00, 5'd7, 1, 32'hA, 5'd7, 5'd7);
    step(0, 0, 2'b00, 5'd7, 1, 32'hB, 5'd7, 5'd7);
    step(0, 0, 2'b00, 5'd7, 1, 32'hC, 5'd7, 5'd7);
    idle(3, 5'd7);

    // Write to r0: propagates but is never forwarded or counted
    step(0, 0, 2'b00, 5'd0, 1, 32'hFFFF, 5'd0, 5'd0);
    idle(3, 5'd0);

    // r3 held in MEM for three cycles, then retires once
    step(0, 0, 2'b00, 5'd3, 1, 32'h55, 5'd3, 5'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b01, 5'd9, 1, 32'h99, 5'd3, 5'd9);
    idle(3, 5'd3);

    // Flush with both stages valid
    step(0, 0, 2'b00, 5'd4, 1, 32'h44, 5'd4, 5'd6);
    step(0, 0, 2'b00, 5'd6, 1, 32'h66, 5'd4, 5'd6);
    step(0, 1, 2'b11, 5'd8, 1, 32'h88, 5'd4, 5'd6);
    idle(2, 5'd4);

    // Reset during a full hold
    step(0, 0, 2'b00, 5'd2, 1, 32'h22, 5'd2, 5'd0);
    step(0, 0, 2'b00, 5'd1, 1, 32'h11, 5'd2, 5'd1);
    step(0, 0, 2'b11, 5'd1, 1, 32'h11, 5'd2, 5'd1);
    step(1, 0, 2'b11, 5'd1, 1, 32'h11, 5'd2, 5'd1);
    idle(2, 5'd2);

    // Enough retiring writes to wrap the counter
    for (int i = 0; i < (1 << CNT_W) + 4; i++)
      step(0, 0, 2'b00, 5'((i % 31) + 1), 1, $urandom, 5'((i % 31) + 1), 5'(i % 32));
    idle(2, 5'd0);

    // Randomized traffic with stalls, flushes, rare reset and the illegal 10 code
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] st;
      int sel;
      sel = $urandom_range(0, 99);
      st = (sel < 60) ? 2'b00 : (sel < 80) ? 2'b01 : (sel < 97) ? 2'b11 : 2'b10;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 24) == 0), st,
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(2, 5'd0);

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk); budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d observations left, expected 0", exp_q.size());
    end
    $display("illegal stall codes driven: %0d", illegal_stalls);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
